// File: rtl/rom_port_arbiter_if.sv
// Bus bundle between the pixel mappers / ROM and the ROM port arbiter.
// The arbiter uses the slave view. The master view drives the requests and the ROM read data.
interface rom_port_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 5
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        grant;
  logic [ADDR_W-1:0]         rom_address;
  logic [DATA_W-1:0]         rom_q;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      busy_stall;

  modport slave (
    input  req, req_addr, rom_q,
    output grant, rom_address, rsp_valid, rsp_data, busy_stall
  );

  modport master (
    output req, req_addr, rom_q,
    input  grant, rom_address, rsp_valid, rsp_data, busy_stall
  );
endinterface

// File: rtl/rom_port_arbiter.sv
// Shares one synchronous-read ROM port among NUM_REQ requesters.
// Requester 0 (scanout) always wins. Requesters 1..NUM_REQ-1 share the leftover slots
// round-robin. Read data comes back one cycle after grant and is tagged with the
// one-hot index of the requester that issued the read.
module rom_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 5
) (
  input logic              vga_clk,
  input logic              reset,
  rom_port_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] PTR_ONE = IDX_W'(1);
  localparam logic [IDX_W-1:0] PTR_MAX = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   ptr_eff;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  logic [ADDR_W-1:0]  win_addr;
  logic [ADDR_W-1:0]  hold_addr;
  logic [NUM_REQ-1:0] grant_c;
  logic [NUM_REQ-1:0] rsp_valid_q;

  // A corrupted pointer (0 or beyond the last requester) restarts the search at requester 1.
  always_comb begin
    ptr_eff = ptr;
    if (ptr == '0 || ptr > PTR_MAX) ptr_eff = PTR_ONE;
  end

  // Pick the winner. Index 0 has absolute priority. Otherwise search upward from ptr and wrap back to 1, never to 0.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    if (bus.req[0]) begin
      win_found = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ - 1; k++) begin
        cand = int'(ptr_eff) + k;
        if (cand > NUM_REQ - 1) cand = cand - (NUM_REQ - 1);
        cand_idx = IDX_W'(cand);
        if (!win_found && bus.req[cand_idx]) begin
          win_found = 1'b1;
          win_idx   = cand_idx;
        end
      end
    end
  end

  // Select the winning address and form the one-hot grant. Reset suppresses the grant.
  always_comb begin
    win_addr = '0;
    grant_c  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_addr   = bus.req_addr[i*ADDR_W +: ADDR_W];
        grant_c[i] = win_found && !reset;
      end
    end
  end

  assign bus.grant       = grant_c;
  assign bus.rom_address = (win_found && !reset) ? win_addr : hold_addr;
  assign bus.rsp_valid   = reset ? '0 : rsp_valid_q;
  assign bus.rsp_data    = bus.rom_q;
  assign bus.busy_stall  = !reset && (|(bus.req[NUM_REQ-1:1] & ~grant_c[NUM_REQ-1:1]));

  // Hold the idle address, advance the round-robin pointer and register the response tag.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      ptr         <= PTR_ONE;
      hold_addr   <= '0;
      rsp_valid_q <= '0;
    end else begin
      rsp_valid_q <= grant_c;
      if (win_found) hold_addr <= win_addr;
      if (win_found && win_idx != '0)
        ptr <= (win_idx == PTR_MAX) ? PTR_ONE : win_idx + PTR_ONE;
    end
  end

endmodule
